// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and HI/LO unit types, reused by decode and
// forwarding logic.
package mips_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // Two's-complement negate when neg is set; used for magnitudes and result signs.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit HI/LO multiply/divide unit: 32 shift-add or restoring-divide
// steps on operand magnitudes, followed by one sign-fixup cycle.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   r_state;
  md_state_t   w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div0;
  logic [31:0] r_opb;
  logic [63:0] r_acc;
  logic [31:0] r_quo;
  logic [31:0] r_rem;

  logic        w_is_md;
  logic        w_accept;
  logic        w_signed;
  logic        w_sa;
  logic        w_sb;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_prod;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_is_md  = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                    (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign w_accept = start && w_is_md && (r_state == IDLE);
  assign w_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign w_sa     = w_signed & rs_val[31];
  assign w_sb     = w_signed & rt_val[31];

  // Multiplier sits in acc[31:0] and shifts out as the product shifts in.
  assign w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opb : 32'd0)};
  // The partial remainder is 33 bits only transiently; after a step it is below the divisor.
  assign w_div_shift = {r_rem, r_quo[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_sub   = w_div_shift[31:0] - r_opb;

  assign w_prod    = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quo_fix = r_div0 ? DIV0_LO : cond_neg32(r_quo, r_neg_q);
  assign w_rem_fix = cond_neg32(r_rem, r_neg_r);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = RUN;
        else          w_state_nxt = IDLE;
      end
      RUN: begin
        if (r_cnt == 5'd31) w_state_nxt = FIX;
        else                w_state_nxt = RUN;
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath, HI/LO and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_opb    <= 32'd0;
      r_acc    <= 64'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy   <= 1'b1;
            r_cnt    <= 5'd0;
            r_is_div <= (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_div0   <= (rt_val == 32'd0);
            r_opb    <= cond_neg32(rt_val, w_sb);
            r_acc    <= {32'd0, cond_neg32(rs_val, w_sa)};
            r_quo    <= cond_neg32(rs_val, w_sa);
            r_rem    <= 32'd0;
          end else if (start && (funct == FUNCT_MTHI)) begin
            r_hi <= rs_val;
          end else if (start && (funct == FUNCT_MTLO)) begin
            r_lo <= rs_val;
          end else begin
            r_busy <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_is_div) begin
            r_rem <= w_div_ge ? w_div_sub : w_div_shift[31:0];
            r_quo <= {r_quo[30:0], w_div_ge};
          end else begin
            r_acc <= {w_mul_sum, r_acc[31:1]};
          end
        end
        FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_is_div) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed boundary cases plus random
// MULT/DIV traffic checked against a plain-arithmetic reference model.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .funct  (funct),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from architectural MIPS rules.
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (f)
      FUNCT_MULTU: res = {32'd0, a} * {32'd0, b};
      FUNCT_MULT: begin
        p = sa * sb;
        res = p;
      end
      FUNCT_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      FUNCT_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Issue one MULT/DIV op, optionally inject a start at E5, and check timing and result.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] inj_f, input logic [31:0] inj_a);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int n;
    bit early, drop;
    exp = ref_md(f, a, b);
    hi0 = hi;
    lo0 = lo;
    start = 1'b1; funct = f; rs_val = a; rt_val = b;
    @(posedge clock); #1;
    start = 1'b0; funct = 6'($urandom); rs_val = $urandom; rt_val = $urandom;
    check("e0_busy", busy, 64'd1);
    check("e0_done", done, 64'd0);
    n = 0; early = 1'b0; drop = 1'b0;
    do begin
      if (n == 4 && inj_f != 6'd0) begin
        start = 1'b1; funct = inj_f; rs_val = inj_a; rt_val = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
      if (done !== 1'b1) begin
        if (busy !== 1'b1) drop = 1'b1;
        if (hi !== hi0 || lo !== lo0) early = 1'b1;
      end
    end while (done !== 1'b1 && n < 40);
    start = 1'b0;
    check("latency", 64'(n), 64'd33);
    check("busy_run", 64'(drop), 64'd0);
    check("hilo_hold", 64'(early), 64'd0);
    check("busy_at_done", busy, 64'd0);
    check("hi", hi, exp[63:32]);
    check("lo", lo, exp[31:0]);
  endtask

  initial begin
    logic [5:0] ops [4];
    logic [31:0] a, b, hi_s, lo_s;
    int n;
    bit seen;
    ops[0] = FUNCT_MULT; ops[1] = FUNCT_MULTU; ops[2] = FUNCT_DIV; ops[3] = FUNCT_DIVU;
    reset = 1'b1; start = 1'b0; funct = 6'd0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_busy", busy, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_hi", hi, 64'd0);
    check("rst_lo", lo, 64'd0);

    run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 32'd0);
    @(posedge clock); #1;
    check("done_once", done, 64'd0);
    check("idle_busy", busy, 64'd0);

    run_op(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 6'd0, 32'd0);
    run_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 6'd0, 32'd0);
    run_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd0, 32'd0);
    run_op(FUNCT_DIVU, 32'h0000_1234, 32'd0, 6'd0, 32'd0);
    run_op(FUNCT_DIV, 32'hFFFF_FF00, 32'd0, 6'd0, 32'd0);

    // MTHI/MTLO while idle, and an unknown funct that must be ignored.
    start = 1'b1; funct = FUNCT_MTHI; rs_val = 32'hA5A5_A5A5;
    @(posedge clock); #1;
    start = 1'b0;
    check("mthi_hi", hi, 64'hA5A5_A5A5);
    check("mthi_busy", busy, 64'd0);
    check("mthi_done", done, 64'd0);
    start = 1'b1; funct = FUNCT_MTLO; rs_val = 32'h5A5A_0F0F;
    @(posedge clock); #1;
    start = 1'b0;
    check("mtlo_lo", lo, 64'h5A5A_0F0F);
    check("mtlo_hi", hi, 64'hA5A5_A5A5);
    start = 1'b1; funct = 6'h20; rs_val = 32'h1111_1111;
    @(posedge clock); #1;
    start = 1'b0;
    check("bad_funct_busy", busy, 64'd0);
    check("bad_funct_hi", hi, 64'hA5A5_A5A5);

    // Starts issued during RUN are dropped.
    run_op(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, FUNCT_MTHI, 32'hA5A5_A5A5);
    run_op(FUNCT_MULTU, 32'd1000, 32'd3000, FUNCT_MULT, 32'h0000_0009);
    @(posedge clock); #1;
    check("inj_no_restart", busy, 64'd0);

    // Back-to-back random traffic, each accepted the edge after done.
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      run_op(ops[$urandom_range(0, 3)], a, b, 6'd0, 32'd0);
    end

    // Reset during a MULT at E10: abort and clear, no done afterwards.
    hi_s = hi; lo_s = lo;
    check("pre_rst_nonzero", 64'((hi_s | lo_s) != 32'd0), 64'd1);
    start = 1'b1; funct = FUNCT_MULT; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    check("pre_rst_busy", busy, 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy", busy, 64'd0);
    check("abort_done", done, 64'd0);
    check("abort_hi", hi, 64'd0);
    check("abort_lo", lo, 64'd0);
    seen = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("no_done_after_abort", 64'(seen), 64'd0);
    check("abort_lo_hold", lo, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
